tick_scheduler: RTL

TICK_SCHEDULER -- requirements
Module: tick_scheduler

---
 rtl/tick_scheduler_if.sv | 15 +
 rtl/tick_scheduler.sv | 86 ++++++++
 2 files changed

// File: rtl/tick_scheduler_if.sv
// tick_scheduler_if: configuration and expiry-event handshakes of the tick scheduler
interface tick_scheduler_if #(parameter int PERIOD_W = 12);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [1:0]          cfg_chan;
  logic [PERIOD_W-1:0] cfg_period;
  logic                cfg_periodic;
  logic                evt_valid;
  logic                evt_ready;
  logic [1:0]          evt_chan;
  modport master(output cfg_valid, cfg_chan, cfg_period, cfg_periodic, evt_ready,
                 input cfg_ready, evt_valid, evt_chan);
  modport slave(input cfg_valid, cfg_chan, cfg_period, cfg_periodic, evt_ready,
                output cfg_ready, evt_valid, evt_chan);
endinterface

// File: rtl/tick_scheduler.sv
// tick_scheduler: four prescaler-driven timer channels with a round-robin expiry event queue
module tick_scheduler #(
  parameter int PERIOD_W = 12,
  parameter int NCH = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             tick,
  tick_scheduler_if.slave  bus,
  output logic [NCH-1:0]   active,
  output logic [NCH-1:0]   overrun
);
  localparam logic [PERIOD_W-1:0] ONE = 1;
  logic [PERIOD_W-1:0] count [NCH];
  logic [PERIOD_W-1:0] period [NCH];
  logic [NCH-1:0] periodic, pending, cfg_hit, expire, grant;
  logic [1:0] ptr, gnt_ch, idx;
  logic gnt_any, load;
  assign bus.cfg_ready = ~reset;
  assign load = ~bus.evt_valid | bus.evt_ready;
  // search starts one past the last granted channel
  always_comb begin
    gnt_any = 1'b0;
    gnt_ch = '0;
    idx = '0;
    cfg_hit = '0;
    expire = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = ptr + 2'(i);
      if (load && !gnt_any && pending[idx]) begin
        gnt_any = 1'b1;
        gnt_ch = idx;
      end
    end
    grant = gnt_any ? {{(NCH-1){1'b0}}, 1'b1} << gnt_ch : '0;
    for (int c = 0; c < NCH; c++) begin
      cfg_hit[c] = bus.cfg_valid && bus.cfg_chan == 2'(c);
      expire[c] = tick && active[c] && count[c] == ONE && !cfg_hit[c];
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        count[c] <= '0;
        period[c] <= '0;
      end
      periodic <= '0;
      active <= '0;
      pending <= '0;
      overrun <= '0;
      bus.evt_valid <= 1'b0;
      bus.evt_chan <= '0;
      ptr <= 2'd3;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (cfg_hit[c]) begin
          if (bus.cfg_period != '0) begin
            count[c] <= bus.cfg_period;
            period[c] <= bus.cfg_period;
            periodic[c] <= bus.cfg_periodic;
            active[c] <= 1'b1;
          end else begin
            active[c] <= 1'b0;
          end
          overrun[c] <= 1'b0;
        end else if (tick && active[c]) begin
          if (count[c] == ONE) begin
            count[c] <= periodic[c] ? period[c] : count[c];
            active[c] <= periodic[c];
            overrun[c] <= overrun[c] | (pending[c] & ~grant[c]);
          end else begin
            count[c] <= count[c] - ONE;
          end
        end
        pending[c] <= expire[c] | (pending[c] & ~grant[c]);
      end
      if (load) begin
        bus.evt_valid <= gnt_any;
        if (gnt_any) begin
          bus.evt_chan <= gnt_ch;
          ptr <= gnt_ch;
        end
      end
    end
  end
endmodule
